mod_exp_r2l: RTL and testbench

MOD_EXP_R2L -- requirements
Module: mod_exp_r2l

---
 rtl/mod_exp_pkg.sv | 12 +
 rtl/mod_exp_r2l_if.sv | 24 ++
 rtl/mod_mult.sv | 54 +++++
 rtl/mod_exp_r2l.sv | 113 +++++++++++
 tb/tb_mod_exp_r2l.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mod_exp_pkg.sv
// Shared constants for the right-to-left modular exponentiator: default width and FSM encoding.
package mod_exp_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StMult = 3'd2;
  localparam logic [2:0] StNext = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

endpackage

// File: rtl/mod_exp_r2l_if.sv
// Request/response and serial-exponent handshake bundle for mod_exp_r2l.
interface mod_exp_r2l_if #(
  parameter int unsigned WIDTH = mod_exp_pkg::DefaultWidth
);
  logic             start;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] modulus;
  logic             exp_bit;
  logic             exp_load;
  logic             exp_shift;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, base, modulus, exp_bit,
    input  exp_load, exp_shift, result, busy, done
  );

  modport slave (
    input  start, base, modulus, exp_bit,
    output exp_load, exp_shift, result, busy, done
  );
endinterface

// File: rtl/mod_mult.sv
// Interleaved MSB-first modular multiplier: p = a*b mod n after WIDTH step cycles.
module mod_mult
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, n_q, acc_q, acc_d;
  logic [WIDTH+1:0] sum, sub1, n_ext;
  logic [CntW-1:0]  cnt_q;

  // acc < n and b < n keep 2*acc + b below 3n, so two subtractions always reduce it.
  always_comb begin
    n_ext = {2'b00, n_q};
    sum   = {1'b0, acc_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    sub1  = (sum >= n_ext) ? sum - n_ext : sum;
    acc_d = WIDTH'((sub1 >= n_ext) ? sub1 - n_ext : sub1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      n_q   <= n;
      acc_q <= '0;
      cnt_q <= CntW'(WIDTH);
    end else if (cnt_q != '0) begin
      a_q   <= a_q << 1;
      acc_q <= acc_d;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign p    = acc_q;
  // High in the cycle whose clock edge writes the final product.
  assign done = (cnt_q == CntW'(1));

endmodule

// File: rtl/mod_exp_r2l.sv
// Right-to-left square-and-multiply modular exponentiator fed by an upstream serial exponent.
module mod_exp_r2l
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic          clk,
  input logic          reset,
  mod_exp_r2l_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d, n_q, n_d, r_q, r_d, result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mul_start, rb_done, bb_done;
  logic [WIDTH-1:0] rb_p, bb_p;

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    n_d       = n_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    mul_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          b_d     = bus.base;
          n_d     = bus.modulus;
          r_d     = WIDTH'(bus.modulus > WIDTH'(1));
          cnt_d   = CntW'(WIDTH);
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (n_q == '0) begin
          result_d = r_q;
          state_d  = StDone;
        end else begin
          mul_start = 1'b1;
          state_d   = StMult;
        end
      end
      StMult: begin
        if (rb_done && bb_done) state_d = StNext;
      end
      StNext: begin
        if (bus.exp_bit) r_d = rb_p;
        b_d   = bb_p;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = r_d;
          state_d  = StDone;
        end else begin
          mul_start = 1'b1;
          state_d   = StMult;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      b_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      n_q      <= n_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Multipliers load the values R and B will hold next, so a restart needs no extra cycle.
  mod_mult #(.WIDTH(WIDTH)) u_mult_rb (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (r_d),
    .b     (b_d),
    .n     (n_q),
    .p     (rb_p),
    .done  (rb_done)
  );

  mod_mult #(.WIDTH(WIDTH)) u_mult_bb (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (b_d),
    .b     (b_d),
    .n     (n_q),
    .p     (bb_p),
    .done  (bb_done)
  );

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.exp_load  = (state_q == StLoad);
  assign bus.exp_shift = (state_q == StNext);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mod_exp_r2l.sv
// Self-checking bench for mod_exp_r2l at WIDTH=8 with a modelled upstream exponent shift register.
module tb_mod_exp_r2l;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] exp_val = '0;
  logic [W-1:0] sr_q;
  int           passed = 0;
  int           total = 0;

  mod_exp_r2l_if #(.WIDTH(W)) bus ();

  mod_exp_r2l #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Upstream serial exponent register, LSB first.
  always @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else if (bus.exp_load) sr_q <= exp_val;
    else if (bus.exp_shift) sr_q <= sr_q >> 1;
  end
  assign bus.exp_bit = sr_q[0];

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] modulus;
    logic [W-1:0] exp;
    logic [W-1:0] result;
    int           lat;
    int           shifts;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [W-1:0] ref_pow(input int unsigned b, input int unsigned m,
                                           input int unsigned e);
    longint unsigned r;
    if (m == 0) return '0;
    r = 64'(1 % m);
    for (int unsigned i = 0; i < e; i++) r = (r * 64'(b)) % 64'(m);
    return r[W-1:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] e,
                        input int inject_at, output logic [W-1:0] res, output int lat,
                        output int loads, output int shifts, output bit busy_ok,
                        output bit overlap);
    int cyc;
    @(negedge clk);
    bus.base    = b;
    bus.modulus = m;
    exp_val     = e;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc       = 1;
    loads     = 0;
    shifts    = 0;
    busy_ok   = 1'b1;
    overlap   = 1'b0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.exp_load === 1'b1) loads++;
      if (bus.exp_shift === 1'b1) shifts++;
      if (bus.exp_load === 1'b1 && bus.exp_shift === 1'b1) overlap = 1'b1;
      if (cyc == inject_at) begin
        bus.start   = 1'b1;
        bus.base    = 8'd4;
        bus.modulus = 8'd9;
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    if (bus.exp_load === 1'b1 || bus.exp_shift === 1'b1) overlap = 1'b1;
    lat = (bus.done === 1'b1) ? cyc : -1;
    res = bus.result;
  endtask

  initial begin
    logic [W-1:0] res, rb, rm, re;
    int           lat, loads, shifts;
    bit           busy_ok, overlap, saw_done;

    vecs[0] = '{base: 8'd3, modulus: 8'd7, exp: 8'd5, result: 8'd5, lat: 74, shifts: 8};
    vecs[1] = '{base: 8'd2, modulus: 8'd13, exp: 8'd0, result: 8'd1, lat: 74, shifts: 8};
    vecs[2] = '{base: 8'd2, modulus: 8'd11, exp: 8'd255, result: 8'd10, lat: 74, shifts: 8};
    vecs[3] = '{base: 8'd0, modulus: 8'd1, exp: 8'd9, result: 8'd0, lat: 74, shifts: 8};
    vecs[4] = '{base: 8'd5, modulus: 8'd1, exp: 8'd200, result: 8'd0, lat: 74, shifts: 8};
    vecs[5] = '{base: 8'd7, modulus: 8'd0, exp: 8'd3, result: 8'd0, lat: 2, shifts: 0};

    bus.start   = 1'b0;
    bus.base    = '0;
    bus.modulus = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_result", int'(bus.result), 0);
    check("reset_exp_load", int'(bus.exp_load), 0);
    check("reset_exp_shift", int'(bus.exp_shift), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].base, vecs[i].modulus, vecs[i].exp, 0, res, lat, loads, shifts,
             busy_ok, overlap);
      check($sformatf("vec%0d_result", i), int'(res), int'(vecs[i].result));
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_loads", i), loads, 1);
      check($sformatf("vec%0d_shifts", i), shifts, vecs[i].shifts);
      check($sformatf("vec%0d_busy", i), int'(busy_ok), 1);
      check($sformatf("vec%0d_no_overlap", i), int'(overlap), 0);
    end

    // Result holds after completion.
    run_op(8'd2, 8'd11, 8'd255, 0, res, lat, loads, shifts, busy_ok, overlap);
    repeat (5) @(negedge clk);
    check("hold_result", int'(bus.result), 10);
    check("hold_idle_busy", int'(bus.busy), 0);

    // Start while busy is ignored.
    run_op(8'd3, 8'd7, 8'd5, 20, res, lat, loads, shifts, busy_ok, overlap);
    check("ignore_start_result", int'(res), 5);
    check("ignore_start_latency", lat, 74);
    check("ignore_start_loads", loads, 1);

    // Reset 30 cycles into an operation.
    @(negedge clk);
    bus.base    = 8'd3;
    bus.modulus = 8'd7;
    exp_val     = 8'd5;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_done", int'(bus.done), 0);
    check("midreset_result", int'(bus.result), 0);
    check("midreset_exp_load", int'(bus.exp_load), 0);
    check("midreset_exp_shift", int'(bus.exp_shift), 0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    check("midreset_no_done", int'(saw_done), 0);
    run_op(8'd3, 8'd7, 8'd5, 0, res, lat, loads, shifts, busy_ok, overlap);
    check("restart_result", int'(res), 5);
    check("restart_latency", lat, 74);

    // Randomized operands against the reference model.
    for (int i = 0; i < 20; i++) begin
      rm = W'($urandom_range(255, 1));
      rb = W'($urandom_range(int'(rm) - 1, 0));
      re = W'($urandom);
      run_op(rb, rm, re, 0, res, lat, loads, shifts, busy_ok, overlap);
      check($sformatf("rand%0d_%0d^%0d_mod_%0d", i, rb, re, rm), int'(res),
            int'(ref_pow(rb, rm, re)));
      check($sformatf("rand%0d_latency", i), lat, 74);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
